// File: rtl/pseudo_softmax_seq_if.sv
// Stream and datapath-side signals of the pseudo-softmax sequencer.
// The sequencer uses the slave view. The I/O shim plus datapath (or a bench) uses the master view.
interface pseudo_softmax_seq_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = 4,
  parameter int MANT_WIDTH = 3
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // element input stream
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;

  // parallel datapath side
  logic [NUM_INPUTS*DATA_WIDTH-1:0] dp_bus;
  logic [NUM_INPUTS*EXP_WIDTH-1:0]  dp_exp;
  logic [MANT_WIDTH-1:0]            dp_mant;

  // result output stream
  logic                             out_valid;
  logic                             out_ready;
  logic [EXP_WIDTH-1:0]             out_exp;
  logic [MANT_WIDTH-1:0]            out_mant;
  logic [IDX_W-1:0]                 out_idx;
  logic                             out_last;

  modport slave (
    input  in_valid, in_data, dp_exp, dp_mant, out_ready,
    output in_ready, dp_bus, out_valid, out_exp, out_mant, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, dp_exp, dp_mant, out_ready,
    input  in_ready, dp_bus, out_valid, out_exp, out_mant, out_idx, out_last
  );
endinterface

// File: rtl/pseudo_softmax_seq.sv
// Pin-limited sequencer around the pseudo-softmax datapath. It gathers NUM_INPUTS
// elements serially into a parallel operand bus. It holds the bus for DP_LATENCY
// cycles, captures the results, and then streams them back one element per beat.
module pseudo_softmax_seq #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = 4,
  parameter int MANT_WIDTH = 3,
  parameter int DP_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  pseudo_softmax_seq_if.slave bus,
  output logic                busy,
  output logic [7:0]          frame_cnt
);
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int WAIT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_CAPTURE, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_out_idx;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_slots [NUM_INPUTS];
  logic [EXP_WIDTH-1:0]  r_exp   [NUM_INPUTS];
  logic [MANT_WIDTH-1:0] r_mant;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [7:0]            r_frame_cnt;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_load_done;
  logic                  w_out_fire;

  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_load_done = w_in_fire && (r_idx == IDX_W'(NUM_INPUTS - 1));
  assign w_out_fire  = r_out_valid && bus.out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next_state;
  end

  // Next-state decode; clear overrides every transition.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:    if (w_load_done) w_next_state = S_WAIT;
        S_WAIT:    if (r_wait_cnt == '0) w_next_state = S_CAPTURE;
        S_CAPTURE: w_next_state = S_STREAM;
        S_STREAM:  if (w_out_fire && r_out_last) w_next_state = S_LOAD;
        default:   w_next_state = S_LOAD;
      endcase
    end
  end

  // State-decoded outputs: input is open only in LOAD, and busy covers everything else.
  always_comb begin
    w_in_ready = (r_state == S_LOAD);
    busy       = (r_state != S_LOAD);
  end

  // Slot loading, latency count, result capture and output sequencing.
  // NOTE: the slot and result arrays are reset because dp_bus and out_exp must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_out_idx   <= '0;
      r_wait_cnt  <= '0;
      r_mant      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_slots[i] <= '0;
        r_exp[i]   <= '0;
      end
    end else if (clear) begin
      // Abort: drop the partial vector but keep dp_bus and captured results.
      r_idx       <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_slots[r_idx] <= bus.in_data;
            if (w_load_done) begin
              r_idx      <= '0;
              r_wait_cnt <= WAIT_W'(DP_LATENCY - 1);
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
        S_CAPTURE: begin
          for (int i = 0; i < NUM_INPUTS; i++) r_exp[i] <= bus.dp_exp[i*EXP_WIDTH +: EXP_WIDTH];
          r_mant      <= bus.dp_mant;
          r_out_valid <= 1'b1;
          r_out_idx   <= '0;
          r_out_last  <= 1'b0;
        end
        S_STREAM: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_idx   <= '0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
              r_out_idx  <= r_out_idx + IDX_W'(1);
              r_out_last <= (r_out_idx == IDX_W'(NUM_INPUTS - 2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_bus
    assign bus.dp_bus[g*DATA_WIDTH +: DATA_WIDTH] = r_slots[g];
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_exp   = r_exp[r_out_idx];
  assign bus.out_mant  = r_mant;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;
  assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_pseudo_softmax_seq.sv
// Self-checking bench for pseudo_softmax_seq. A delayed datapath model drives dp_exp/dp_mant.
// Expected beats are queued when a vector is sent and popped as the DUT streams them out.
module tb_pseudo_softmax_seq;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int EW  = 4;
  localparam int MW  = 3;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic [7:0] frame_cnt;

  pseudo_softmax_seq_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .EXP_WIDTH(EW), .MANT_WIDTH(MW)) bus ();

  pseudo_softmax_seq #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .EXP_WIDTH(EW), .MANT_WIDTH(MW), .DP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: results reflect the operand bus as it was LAT edges earlier.
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  always @(posedge clk) begin
    d1 <= bus.dp_bus;
    d2 <= d1;
  end

  bit model_mode = 1'b0;

  function automatic logic [3:0] model_exp(input logic [31:0] v, input int i, input bit mode);
    if (mode == 1'b0) return 4'(i + 5);
    return v[i*8 +: 4] ^ 4'(i * 3);
  endfunction

  function automatic logic [2:0] model_mant(input logic [31:0] v, input bit mode);
    if (mode == 1'b0) return 3'd3;
    return v[2:0] ^ v[26:24];
  endfunction

  always_comb begin
    bus.dp_mant = model_mant(d2, model_mode);
    for (int i = 0; i < N; i++) bus.dp_exp[i*4 +: 4] = model_exp(d2, i, model_mode);
  end

  typedef struct packed {
    logic [3:0] exp;
    logic [2:0] mant;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          t_acc = 0;
  logic [31:0] cur_bus = '0;
  logic [7:0]  exp_frames = '0;

  // One input handshake; t_acc records the accepting edge number.
  task automatic accept_one(input logic [7:0] d);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%0b want 1", bus.in_ready);
    end
    t_acc = cyc + 1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Send one vector, optionally with idle gaps and with junk in_valid left asserted afterwards.
  task automatic send_vec(input logic [31:0] v, input int gap, input bit junk_after);
    for (int i = 0; i < N; i++) begin
      accept_one(v[i*8 +: 8]);
      if (gap > 0 && i < N - 1) begin
        bus.in_data = 8'hA5;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    cur_bus = v;
    for (int i = 0; i < N; i++)
      sb.push_back('{exp: model_exp(v, i, model_mode), mant: model_mant(v, model_mode),
                     idx: 2'(i), last: (i == N - 1)});
    checks++;
    if (bus.dp_bus !== v) begin
      errors++;
      $display("FAIL dp_bus_load got %h want %h", bus.dp_bus, v);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_last got %0b want 1", busy);
    end
    if (junk_after) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
    end
  endtask

  // Drain one vector, optionally stalling out_ready at beat stall_idx.
  task automatic recv_vec(input int stall_idx, input int stall_cycles);
    beat_t e;
    int    budget;
    bus.out_ready = 1'b1;
    for (int b = 0; b < N; b++) begin
      budget = 0;
      @(negedge clk);
      while (!bus.out_valid && budget < 50) begin
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1 || bus.dp_bus !== cur_bus) begin
          errors++;
          $display("FAIL wait_hold got rdy=%0b busy=%0b bus=%h want rdy=0 busy=1 bus=%h",
                   bus.in_ready, busy, bus.dp_bus, cur_bus);
        end
        budget++;
        @(negedge clk);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_timeout got %0b want 1", bus.out_valid);
        return;
      end
      if (b == 0) begin
        checks++;
        if (cyc !== t_acc + LAT + 1) begin
          errors++;
          $display("FAIL out_valid_latency got edge %0d want %0d", cyc, t_acc + LAT + 1);
        end
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got 0 entries want >0");
        return;
      end
      e = sb.pop_front();
      if (b == stall_idx) begin
        bus.out_ready = 1'b0;
        repeat (stall_cycles) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1 || {bus.out_exp, bus.out_mant, bus.out_idx, bus.out_last} !== e) begin
            errors++;
            $display("FAIL stall_hold got v=%0b beat=%h want v=1 beat=%h", bus.out_valid,
                     {bus.out_exp, bus.out_mant, bus.out_idx, bus.out_last}, e);
          end
        end
        bus.out_ready = 1'b1;
      end
      checks++;
      if ({bus.out_exp, bus.out_mant, bus.out_idx, bus.out_last} !== e || bus.dp_bus !== cur_bus) begin
        errors++;
        $display("FAIL beat%0d got beat=%h bus=%h want beat=%h bus=%h", b,
                 {bus.out_exp, bus.out_mant, bus.out_idx, bus.out_last}, bus.dp_bus, e, cur_bus);
      end
      @(posedge clk);
      #1;
    end
    exp_frames++;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL after_last got v=%0b rdy=%0b frames=%0d want v=0 rdy=1 frames=%0d",
               bus.out_valid, bus.in_ready, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dp_bus, frame_cnt, bus.out_exp, bus.out_mant, bus.out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_values got bus=%h frames=%0d exp=%h mant=%h idx=%0d want all 0",
               bus.dp_bus, frame_cnt, bus.out_exp, bus.out_mant, bus.out_idx);
    end
    checks++;
    if ({bus.out_valid, bus.out_last, busy, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags got %b want 0001", {bus.out_valid, bus.out_last, busy, bus.in_ready});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    model_mode = 1'b0;
    send_vec(32'h44332211, 0, 0);
    recv_vec(-1, 0);
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    model_mode = 1'b1;
    send_vec(32'h87654321, 0, 0);
    recv_vec(1, 5);
  endtask

  task automatic test_ignore_valid();
    model_mode = 1'b1;
    send_vec(32'hF0E1D2C3, 1, 1);
    recv_vec(-1, 0);
    bus.in_valid = 1'b0;
    send_vec(32'h0123A5B6, 0, 0);
    recv_vec(-1, 0);
  endtask

  task automatic test_clear();
    model_mode = 1'b1;
    accept_one(8'h5A);
    accept_one(8'hC3);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL after_clear got rdy=%0b busy=%0b v=%0b frames=%0d want rdy=1 busy=0 v=0 frames=%0d",
               bus.in_ready, busy, bus.out_valid, frame_cnt, exp_frames);
    end
    send_vec(32'h9B7E641D, 0, 0);
    recv_vec(-1, 0);
  endtask

  task automatic test_reset_mid_stream();
    int budget;
    model_mode = 1'b1;
    send_vec(32'h3C5A7E91, 0, 0);
    bus.out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      budget = 0;
      @(negedge clk);
      while (!bus.out_valid && budget < 50) begin
        budget++;
        @(negedge clk);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'(b)) begin
        errors++;
        $display("FAIL mid_beat%0d got v=%0b idx=%0d want v=1 idx=%0d", b, bus.out_valid, bus.out_idx, b);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.out_idx !== 2'd2) begin
      errors++;
      $display("FAIL mid_idx got %0d want 2", bus.out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dp_bus, frame_cnt, bus.out_exp, bus.out_mant, bus.out_idx} !== '0 ||
        {bus.out_valid, bus.out_last, busy, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset got bus=%h frames=%0d idx=%0d flags=%b want zeros flags=0001",
               bus.dp_bus, frame_cnt, bus.out_idx, {bus.out_valid, bus.out_last, busy, bus.in_ready});
    end
    sb.delete();
    exp_frames = '0;
    cur_bus = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL after_release got rdy=%0b busy=%0b frames=%0d want 1 0 0", bus.in_ready, busy, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int prev = 0;
    model_mode = 1'b1;
    for (int v = 0; v < 257; v++) begin
      send_vec($urandom, 0, 0);
      if (v > 0) begin
        checks++;
        if (t_acc - prev !== 2 * N + LAT + 1) begin
          errors++;
          $display("FAIL period%0d got %0d want %0d", v, t_acc - prev, 2 * N + LAT + 1);
        end
      end
      prev = t_acc;
      recv_vec(-1, 0);
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wrap_frame_cnt got %0d want 1", frame_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_valid();
    test_clear();
    test_reset_mid_stream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
